// File: rtl/bp_watch_unit.sv
// Breakpoint/watchpoint unit: NUM_BP masked address comparators on the CPU bus,
// each with read/write qualifiers, a pass count and one-shot mode, plus a
// 128-word register window, sticky status, captured hit address and a
// pending/ack handshake toward the interrupt logic.
module bp_watch_unit #(
  parameter int          NUM_BP = 4,
  parameter int          ADDR_W = 32,
  parameter int          CNT_W  = 8,
  parameter logic [31:0] BASE   = 32'hFFFFF000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  input  logic              we_i,
  input  logic              re_i,
  output logic [15:0]       rdata_o,
  output logic              rvalid_o,
  output logic              sel_o,
  output logic              bp_hit_o,
  output logic [2:0]        bp_chan_o,
  output logic              bp_pending_o,
  input  logic              bp_ack_i,
  output logic [ADDR_W-1:0] handler_addr_o
);

  logic              chEn_q      [NUM_BP];
  logic              chMatchRd_q [NUM_BP];
  logic              chMatchWr_q [NUM_BP];
  logic              chOneShot_q [NUM_BP];
  logic [ADDR_W-1:0] chAddr_q    [NUM_BP];
  logic [ADDR_W-1:0] chMask_q    [NUM_BP];
  logic [CNT_W-1:0]  chCount_q   [NUM_BP];
  logic [CNT_W-1:0]  chRemain_q  [NUM_BP];

  logic [NUM_BP-1:0] status_q, status_d;
  logic [ADDR_W-1:0] handler_q, last_q;
  logic              pending_q, pending_d;
  logic              bpHit_q;
  logic [2:0]        bpChan_q;
  logic [15:0]       rdata_q, rdNext;
  logic              rvalid_q;

  logic [6:0]        offset;
  logic              isChan, winWr, winRd;
  logic [2:0]        chanIdx, regK;
  logic [NUM_BP-1:0] qual, hit, clearMask;
  logic              anyHit;
  logic [2:0]        hitIdx;

  // Upper half of an address-wide value, zero-extended to a 16-bit register.
  function automatic logic [15:0] hiHalf(input logic [ADDR_W-1:0] v);
    return 16'(v >> 16);
  endfunction

  // The window is 128-aligned, so decoding only compares the bits above offset.
  assign sel_o   = (re_i | we_i) & (addr_i[ADDR_W-1:7] == BASE[ADDR_W-1:7]);
  assign offset  = addr_i[6:0];
  assign isChan  = ~offset[6];
  assign chanIdx = offset[5:3];
  assign regK    = offset[2:0];
  assign winWr   = we_i & sel_o;
  assign winRd   = re_i & sel_o;

  // Per-channel qualification and hit detection; window accesses never qualify.
  always_comb begin
    qual   = '0;
    hit    = '0;
    hitIdx = '0;
    for (int c = 0; c < NUM_BP; c++) begin
      qual[c] = chEn_q[c] & ~sel_o
              & ((re_i & chMatchRd_q[c]) | (we_i & chMatchWr_q[c]))
              & (((addr_i ^ chAddr_q[c]) & ~chMask_q[c]) == '0);
      hit[c]  = qual[c] & (chRemain_q[c] == '0);
    end
    for (int c = NUM_BP - 1; c >= 0; c--) begin
      if (hit[c]) hitIdx = 3'(c);
    end
  end

  assign anyHit = |hit;

  // A new hit on a bit wins over a simultaneous write-1-to-clear; a hit also wins over ack.
  always_comb begin
    clearMask = '0;
    if (winWr && offset == 7'h40) clearMask = wdata_i[NUM_BP-1:0];
    status_d  = (status_q & ~clearMask) | hit;
    pending_d = anyHit | (pending_q & ~bp_ack_i);
  end

  // Register read multiplexer; unused offsets and absent channels read zero.
  always_comb begin
    rdNext = '0;
    if (isChan) begin
      for (int c = 0; c < NUM_BP; c++) begin
        if (chanIdx == 3'(c)) begin
          case (regK)
            3'd0:    rdNext = {12'd0, chOneShot_q[c], chMatchWr_q[c], chMatchRd_q[c], chEn_q[c]};
            3'd1:    rdNext = chAddr_q[c][15:0];
            3'd2:    rdNext = hiHalf(chAddr_q[c]);
            3'd3:    rdNext = chMask_q[c][15:0];
            3'd4:    rdNext = hiHalf(chMask_q[c]);
            3'd5:    rdNext = 16'(chCount_q[c]);
            3'd6:    rdNext = 16'(chRemain_q[c]);
            default: rdNext = '0;
          endcase
        end
      end
    end else begin
      case (offset[5:0])
        6'h00:   rdNext = 16'(status_q);
        6'h01:   rdNext = handler_q[15:0];
        6'h02:   rdNext = hiHalf(handler_q);
        6'h03:   rdNext = last_q[15:0];
        6'h04:   rdNext = hiHalf(last_q);
        default: rdNext = '0;
      endcase
    end
  end

  // Channel configuration writes, pass counting and one-shot disarm.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_BP; c++) begin
        chEn_q[c]      <= 1'b0;
        chMatchRd_q[c] <= 1'b0;
        chMatchWr_q[c] <= 1'b0;
        chOneShot_q[c] <= 1'b0;
        chAddr_q[c]    <= '0;
        chMask_q[c]    <= '0;
        chCount_q[c]   <= '0;
        chRemain_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_BP; c++) begin
        if (winWr && isChan && chanIdx == 3'(c)) begin
          case (regK)
            3'd0: begin
              chEn_q[c]      <= wdata_i[0];
              chMatchRd_q[c] <= wdata_i[1];
              chMatchWr_q[c] <= wdata_i[2];
              chOneShot_q[c] <= wdata_i[3];
              if (!chEn_q[c] && wdata_i[0]) chRemain_q[c] <= chCount_q[c];
            end
            3'd1: chAddr_q[c][15:0]        <= wdata_i;
            3'd2: chAddr_q[c][ADDR_W-1:16] <= wdata_i[ADDR_W-17:0];
            3'd3: chMask_q[c][15:0]        <= wdata_i;
            3'd4: chMask_q[c][ADDR_W-1:16] <= wdata_i[ADDR_W-17:0];
            3'd5: begin
              chCount_q[c]  <= wdata_i[CNT_W-1:0];
              chRemain_q[c] <= wdata_i[CNT_W-1:0];
            end
            default: ;
          endcase
        end else if (qual[c]) begin
          if (chRemain_q[c] != '0) begin
            chRemain_q[c] <= chRemain_q[c] - CNT_W'(1);
          end else begin
            chRemain_q[c] <= chCount_q[c];
            if (chOneShot_q[c]) chEn_q[c] <= 1'b0;
          end
        end
      end
    end
  end

  // Global registers, hit reporting and the first-hit address capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q  <= '0;
      handler_q <= '0;
      last_q    <= '0;
      pending_q <= 1'b0;
      bpHit_q   <= 1'b0;
      bpChan_q  <= '0;
    end else begin
      status_q  <= status_d;
      pending_q <= pending_d;
      bpHit_q   <= anyHit;
      if (anyHit) bpChan_q <= hitIdx;
      if (anyHit && !pending_q) last_q <= addr_i;
      if (winWr && offset == 7'h41) handler_q[15:0] <= wdata_i;
      if (winWr && offset == 7'h42) handler_q[ADDR_W-1:16] <= wdata_i[ADDR_W-17:0];
    end
  end

  // Registered read port: data and valid one cycle after a window read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= winRd;
      if (winRd) rdata_q <= rdNext;
    end
  end

  assign rdata_o        = rdata_q;
  assign rvalid_o       = rvalid_q;
  assign bp_hit_o       = bpHit_q;
  assign bp_chan_o      = bpChan_q;
  assign bp_pending_o   = pending_q;
  assign handler_addr_o = handler_q;

endmodule

// File: tb/tb_bp_watch_unit.sv
// Scoreboard bench for bp_watch_unit: directed bus accesses push expected
// read data and hit channels; a negedge monitor pops and compares them.
module tb_bp_watch_unit;

  localparam logic [31:0] BASE = 32'hFFFFF000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic        we, re, bp_ack;
  logic [15:0] rdata;
  logic        rvalid, sel, bp_hit, bp_pending;
  logic [2:0]  bp_chan;
  logic [31:0] handler_addr;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] rdExpQ[$];
  int          rdTagQ[$];
  int          hitQ[$];
  logic [15:0] monExp;
  int          monTag;
  int          monChan;

  bp_watch_unit #(.NUM_BP(4), .ADDR_W(32), .CNT_W(8), .BASE(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wdata_i(wdata),
    .we_i(we), .re_i(re), .rdata_o(rdata), .rvalid_o(rvalid), .sel_o(sel),
    .bp_hit_o(bp_hit), .bp_chan_o(bp_chan), .bp_pending_o(bp_pending),
    .bp_ack_i(bp_ack), .handler_addr_o(handler_addr)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] timeout");
  end

  // Monitor: compares every read response and every hit pulse against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        compared++;
        if (rdExpQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL read-unexpected: rvalid=1 rdata=%h, required no response", rdata);
        end else begin
          monExp = rdExpQ.pop_front();
          monTag = rdTagQ.pop_front();
          if (rdata !== monExp) begin
            mismatched++;
            $display("[TB] FAIL read off=0x%02h: got %h, required %h", monTag, rdata, monExp);
          end
        end
      end
      if (bp_hit) begin
        compared++;
        if (hitQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL hit-unexpected: bp_hit=1 bp_chan=%0d, required no hit", bp_chan);
        end else begin
          monChan = hitQ.pop_front();
          if (32'(bp_chan) !== 32'(monChan)) begin
            mismatched++;
            $display("[TB] FAIL hit-chan: got %0d, required %0d", bp_chan, monChan);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [15:0] d, input logic ack);
    @(posedge clk);
    #1;
    re = r; we = w; addr = a; wdata = d; bp_ack = ack;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
  endtask

  task automatic regWrite(input logic [6:0] off, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, BASE + {25'd0, off}, d, 1'b0);
  endtask

  task automatic regRead(input logic [6:0] off, input logic [15:0] exp);
    applyStimulus(1'b1, 1'b0, BASE + {25'd0, off}, 16'h0, 1'b0);
    rdExpQ.push_back(exp);
    rdTagQ.push_back(int'(off));
  endtask

  task automatic busAccess(input logic r, input logic w, input logic [31:0] a,
                           input bit expHit, input int chan);
    applyStimulus(r, w, a, 16'hA5A5, 1'b0);
    if (expHit) hitQ.push_back(chan);
  endtask

  task automatic ackPulse();
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
    idle();
  endtask

  initial begin
    rst_n = 1'b0; re = 1'b0; we = 1'b0; bp_ack = 1'b0; addr = '0; wdata = '0;
    #1;
    checkOutput("reset-rdata", 32'(rdata), 32'h0);
    checkOutput("reset-rvalid", 32'(rvalid), 32'h0);
    checkOutput("reset-hit", 32'(bp_hit), 32'h0);
    checkOutput("reset-pending", 32'(bp_pending), 32'h0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Whole register window reads zero after reset.
    for (int o = 0; o <= 'h44; o++) regRead(7'(o), 16'h0000);
    regRead(7'h7F, 16'h0000);
    idle();

    // Handler address registers.
    regWrite(7'h41, 16'hBEEF);
    regWrite(7'h42, 16'h1234);
    regRead(7'h41, 16'hBEEF);
    regRead(7'h42, 16'h1234);
    idle();
    checkOutput("handler-addr", handler_addr, 32'h1234BEEF);

    // Ch0 exact read breakpoint at 0x123.
    regWrite(7'h01, 16'h0123);
    regWrite(7'h02, 16'h0000);
    regWrite(7'h05, 16'h0000);
    regWrite(7'h00, 16'h0003);
    busAccess(1'b1, 1'b0, 32'h00000123, 1'b1, 0);
    idle();
    checkOutput("ch0-pending", 32'(bp_pending), 32'h1);
    regRead(7'h40, 16'h0001);
    regRead(7'h43, 16'h0123);
    regRead(7'h44, 16'h0000);
    ackPulse();
    checkOutput("ch0-ack-clears", 32'(bp_pending), 32'h0);
    regWrite(7'h40, 16'h0001);
    regRead(7'h40, 16'h0000);

    // Ch1 masked write watchpoint on 0x100000xx.
    regWrite(7'h09, 16'h0000);
    regWrite(7'h0A, 16'h1000);
    regWrite(7'h0B, 16'h00FF);
    regWrite(7'h08, 16'h0005);
    busAccess(1'b1, 1'b0, 32'h10000042, 1'b0, 0);
    busAccess(1'b0, 1'b1, 32'h10000042, 1'b1, 1);
    busAccess(1'b0, 1'b1, 32'h10000142, 1'b0, 0);
    regRead(7'h43, 16'h0042);
    regRead(7'h44, 16'h1000);
    regRead(7'h40, 16'h0002);
    ackPulse();
    regWrite(7'h40, 16'h0002);

    // Ch2 pass count 2, one-shot.
    regWrite(7'h11, 16'h0400);
    regWrite(7'h15, 16'h0002);
    regWrite(7'h10, 16'h000B);
    regRead(7'h16, 16'h0002);
    busAccess(1'b1, 1'b0, 32'h00000400, 1'b0, 0);
    regRead(7'h16, 16'h0001);
    busAccess(1'b1, 1'b0, 32'h00000400, 1'b0, 0);
    regRead(7'h16, 16'h0000);
    busAccess(1'b1, 1'b0, 32'h00000400, 1'b1, 2);
    regRead(7'h10, 16'h000A);
    busAccess(1'b1, 1'b0, 32'h00000400, 1'b0, 0);
    regRead(7'h16, 16'h0002);
    regRead(7'h40, 16'h0004);
    ackPulse();
    regWrite(7'h40, 16'h0004);

    // Ch0 and ch3 both on 0x200, ch2 re-armed on 0x300.
    regWrite(7'h01, 16'h0200);
    regWrite(7'h19, 16'h0200);
    regWrite(7'h18, 16'h0003);
    regWrite(7'h11, 16'h0300);
    regWrite(7'h15, 16'h0000);
    regWrite(7'h10, 16'h0003);
    busAccess(1'b1, 1'b0, 32'h00000200, 1'b1, 0);
    idle();
    checkOutput("dual-pending", 32'(bp_pending), 32'h1);
    regRead(7'h40, 16'h0009);
    regRead(7'h43, 16'h0200);
    regWrite(7'h40, 16'h0001);
    regRead(7'h40, 16'h0008);
    busAccess(1'b1, 1'b0, 32'h00000300, 1'b1, 2);
    regRead(7'h43, 16'h0200);
    regRead(7'h40, 16'h000C);

    // Hit and ack together keep pending set; ack alone then clears it.
    applyStimulus(1'b1, 1'b0, 32'h00000200, 16'h0, 1'b1);
    hitQ.push_back(0);
    idle();
    checkOutput("hit-ack-same-cycle", 32'(bp_pending), 32'h1);
    ackPulse();
    checkOutput("ack-after-hit", 32'(bp_pending), 32'h0);

    // Asynchronous reset in the middle of a count with a hit pending.
    regWrite(7'h15, 16'h0003);
    busAccess(1'b1, 1'b0, 32'h00000300, 1'b0, 0);
    busAccess(1'b1, 1'b0, 32'h00000200, 1'b1, 0);
    regRead(7'h16, 16'h0002);
    idle();
    idle();
    checkOutput("pre-reset-pending", 32'(bp_pending), 32'h1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async-reset-pending", 32'(bp_pending), 32'h0);
    checkOutput("async-reset-rdata", 32'(rdata), 32'h0);
    checkOutput("async-reset-hit", 32'(bp_hit), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    regRead(7'h16, 16'h0000);
    regRead(7'h10, 16'h0000);
    regRead(7'h40, 16'h0000);
    busAccess(1'b1, 1'b0, 32'h00000200, 1'b0, 0);
    idle();
    idle();
    checkOutput("post-reset-pending", 32'(bp_pending), 32'h0);
    checkOutput("post-reset-handler", handler_addr, 32'h0);

    repeat (3) idle();
    checkOutput("read-queue-drained", 32'(rdExpQ.size()), 32'h0);
    checkOutput("hit-queue-drained", 32'(hitQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
